// File: rtl/ram_responder.sv
// Word-wide backing memory with programmable read/write latency and a one-cycle
// recovery gap after each ready pulse, answering the cache-side external RAM port.
module ram_responder #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] ram_address,
  input  logic                     ram_rd,
  input  logic                     ram_wr,
  input  logic [31:0]              ram_data_wr,
  input  logic [3:0]               ram_byte_enable,
  output logic [31:0]              ram_data_rd,
  output logic                     ram_ready,
  output logic                     protocol_error,
  output logic [1:0]               o_dbg_state
);

  localparam int WORD_AW = ADDRESS_WIDTH - 2;
  localparam int DEPTH   = 1 << WORD_AW;
  localparam int MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
  localparam int CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  generate
    if (READ_LATENCY < 1) begin : g_bad_read_latency
      $error("ram_responder: READ_LATENCY must be >= 1");
    end
    if (WRITE_LATENCY < 1) begin : g_bad_write_latency
      $error("ram_responder: WRITE_LATENCY must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESPOND = 2'd2,
    S_RECOVER = 2'd3
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_cnt;
  logic [WORD_AW-1:0] r_addr;
  logic [31:0]        r_wdata;
  logic [3:0]         r_be;
  logic               r_is_wr;
  logic [31:0]        r_mem [0:DEPTH-1];

  logic               w_start;
  logic [CW-1:0]      w_lat_m1;
  logic               w_held;
  logic               w_go_respond;
  logic [WORD_AW-1:0] w_acc_addr;
  logic               w_acc_wr;
  logic [31:0]        w_acc_data;
  logic [3:0]         w_acc_be;
  logic               w_unused_lsbs;

  assign w_unused_lsbs = ^ram_address[1:0];
  assign o_dbg_state   = r_state;

  // Access fields come straight from the inputs on the IDLE edge (latency 1 case),
  // otherwise from the values latched when the request was accepted.
  always_comb begin
    w_start      = (r_state == S_IDLE) && (ram_rd || ram_wr);
    w_lat_m1     = ram_wr ? CW'(WRITE_LATENCY - 1) : CW'(READ_LATENCY - 1);
    w_held       = r_is_wr ? ram_wr : ram_rd;
    w_go_respond = (w_start && (w_lat_m1 == '0)) ||
                   ((r_state == S_WAIT) && w_held && (r_cnt == CW'(1)));
    if (r_state == S_IDLE) begin
      w_acc_addr = ram_address[ADDRESS_WIDTH-1:2];
      w_acc_wr   = ram_wr;
      w_acc_data = ram_data_wr;
      w_acc_be   = ram_byte_enable;
    end else begin
      w_acc_addr = r_addr;
      w_acc_wr   = r_is_wr;
      w_acc_data = r_wdata;
      w_acc_be   = r_be;
    end
  end

  // Contents survive reset; a write only lands on its RESPOND-entry edge.
  always_ff @(posedge clk) begin
    if (!rst && w_go_respond && w_acc_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_be[i]) r_mem[w_acc_addr][8*i +: 8] <= w_acc_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_addr         <= '0;
      r_wdata        <= '0;
      r_be           <= '0;
      r_is_wr        <= 1'b0;
      ram_ready      <= 1'b0;
      ram_data_rd    <= '0;
      protocol_error <= 1'b0;
    end else begin
      ram_ready <= w_go_respond;
      if (w_go_respond && !w_acc_wr) ram_data_rd <= r_mem[w_acc_addr];
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_addr  <= ram_address[ADDRESS_WIDTH-1:2];
            r_wdata <= ram_data_wr;
            r_be    <= ram_byte_enable;
            r_is_wr <= ram_wr;
            r_cnt   <= w_lat_m1;
            if (ram_rd && ram_wr) protocol_error <= 1'b1;
            r_state <= (w_lat_m1 == '0) ? S_RESPOND : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!w_held) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else if (r_cnt == CW'(1)) begin
            r_cnt   <= '0;
            r_state <= S_RESPOND;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RESPOND: r_state <= S_RECOVER;
        S_RECOVER: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Bench for ram_responder: vector table, multi-cycle corner sequences, randomized
// traffic against a word-array model, and a latency-1 instance.
module tb_ram_responder;

  localparam int RL = 4;
  localparam int WL = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] ram_address;
  logic        ram_rd, ram_wr;
  logic [31:0] ram_data_wr;
  logic [3:0]  ram_byte_enable;
  logic [31:0] ram_data_rd;
  logic        ram_ready, protocol_error;
  logic [1:0]  dbg_state;

  logic [15:0] d1_addr;
  logic        d1_rd, d1_wr;
  logic [31:0] d1_wd;
  logic [3:0]  d1_be;
  logic [31:0] d1_rdata;
  logic        d1_ready, d1_perr;
  logic [1:0]  d1_state;

  ram_responder #(.ADDRESS_WIDTH(16), .READ_LATENCY(RL), .WRITE_LATENCY(WL)) u_dut (
    .clk(clk), .rst(rst), .ram_address(ram_address), .ram_rd(ram_rd), .ram_wr(ram_wr),
    .ram_data_wr(ram_data_wr), .ram_byte_enable(ram_byte_enable), .ram_data_rd(ram_data_rd),
    .ram_ready(ram_ready), .protocol_error(protocol_error), .o_dbg_state(dbg_state)
  );

  ram_responder #(.ADDRESS_WIDTH(16), .READ_LATENCY(1), .WRITE_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .ram_address(d1_addr), .ram_rd(d1_rd), .ram_wr(d1_wr),
    .ram_data_wr(d1_wd), .ram_byte_enable(d1_be), .ram_data_rd(d1_rdata),
    .ram_ready(d1_ready), .protocol_error(d1_perr), .o_dbg_state(d1_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_mem [0:16383];
  logic [31:0] last_rd;

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic chki(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // Raise the request lines at a negedge, wait (bounded) for ready, drop them,
  // then confirm the pulse lasted one cycle and the read data is held.
  task automatic do_op(input string nm, input logic rd_line, input logic wr_line,
                       input logic [15:0] addr, input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] rd_at, output logic [31:0] rd_after, output int lat);
    @(negedge clk);
    ram_address = addr; ram_rd = rd_line; ram_wr = wr_line;
    ram_data_wr = wd; ram_byte_enable = be;
    lat = -1;
    rd_at = 'x;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (ram_ready) begin
        lat = k;
        rd_at = ram_data_rd;
        break;
      end
    end
    ram_rd = 1'b0; ram_wr = 1'b0;
    @(negedge clk);
    chki({nm, "_pulse_width"}, int'(ram_ready), 0);
    rd_after = ram_data_rd;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  typedef struct {
    logic        is_wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    int lat, rdy_cnt, w, seen;
    int rdy_t[4];
    logic [31:0] rdy_d[4];
    logic is_wr;
    logic [15:0] addr;
    logic [31:0] wd, exp_v;
    logic [3:0] be;

    vecs[0] = '{1'b0, 16'h0040, 32'h0,        4'h0,    32'hDEADBEEF, RL};
    vecs[1] = '{1'b1, 16'h0080, 32'hAABBCCDD, 4'b0101, 32'hDEADBEEF, WL};
    vecs[2] = '{1'b0, 16'h0080, 32'h0,        4'h0,    32'h11BB33DD, RL};
    vecs[3] = '{1'b1, 16'h0082, 32'h55667788, 4'b1010, 32'h11BB33DD, WL};
    vecs[4] = '{1'b0, 16'h0083, 32'h0,        4'h0,    32'h55BB77DD, RL};
    vecs[5] = '{1'b1, 16'h0084, 32'h12345678, 4'b0000, 32'h55BB77DD, WL};
    vecs[6] = '{1'b0, 16'h0084, 32'h0,        4'h0,    32'hCAFEF00D, RL};
    vecs[7] = '{1'b1, 16'hFFFC, 32'h0BADC0DE, 4'b1111, 32'hCAFEF00D, WL};
    vecs[8] = '{1'b0, 16'hFFFC, 32'h0,        4'h0,    32'h0BADC0DE, RL};
    vecs[9] = '{1'b0, 16'h0000, 32'h0,        4'h0,    32'h01020304, RL};

    // clock/reset block
    rst = 1'b1;
    ram_address = '0; ram_rd = 1'b0; ram_wr = 1'b0; ram_data_wr = '0; ram_byte_enable = '0;
    d1_addr = '0; d1_rd = 1'b0; d1_wr = 1'b0; d1_wd = '0; d1_be = '0;
    u_dut.r_mem[16'h10] = 32'hDEADBEEF;
    u_dut.r_mem[16'h20] = 32'h11223344;
    u_dut.r_mem[16'h21] = 32'hCAFEF00D;
    u_dut.r_mem[16'h22] = 32'h0;
    u_dut.r_mem[16'h23] = 32'h0;
    u_dut.r_mem[16'h80] = 32'h0;
    u_dut.r_mem[16'h0]  = 32'h01020304;
    for (int i = 0; i < 4; i++) u_dut.r_mem[16'h40 + i] = 32'hA0000000 + i;
    for (int i = 0; i < 16; i++) begin
      model_mem[16'h300 + i] = 32'h5A000000 + (i << 8) + i;
      u_dut.r_mem[16'h300 + i] = 32'h5A000000 + (i << 8) + i;
    end
    u_dut1.r_mem[5] = 32'h55555555;
    u_dut1.r_mem[6] = 32'h66666666;
    repeat (3) @(negedge clk);
    chki("reset_ready", int'(ram_ready), 0);
    chk32("reset_data_rd", ram_data_rd, 32'h0);
    chki("reset_protocol_error", int'(protocol_error), 0);
    chki("reset_state_idle", int'(dbg_state), 0);
    chki("reset_l1_ready", int'(d1_ready), 0);
    rst = 1'b0;

    // table-driven vectors
    for (int i = 0; i < 10; i++) begin
      do_op($sformatf("vec%0d", i), !vecs[i].is_wr, vecs[i].is_wr, vecs[i].addr,
            vecs[i].wdata, vecs[i].be, ra, rb, lat);
      chki($sformatf("vec%0d_latency", i), lat, vecs[i].exp_lat);
      chk32($sformatf("vec%0d_data", i), ra, vecs[i].exp_rd);
      chk32($sformatf("vec%0d_data_held", i), rb, vecs[i].exp_rd);
    end
    last_rd = 32'h01020304;

    // line fill: request held, address advanced after each ready
    rdy_cnt = 0;
    for (int i = 0; i < 4; i++) begin rdy_t[i] = -1; rdy_d[i] = 'x; end
    @(negedge clk);
    ram_address = 16'h0100; ram_rd = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (ram_ready) begin
        if (rdy_cnt < 4) begin rdy_t[rdy_cnt] = k; rdy_d[rdy_cnt] = ram_data_rd; end
        rdy_cnt++;
        if (rdy_cnt >= 4) ram_rd = 1'b0;
        else ram_address = ram_address + 16'd4;
      end
    end
    chki("fill_ready_count", rdy_cnt, 4);
    for (int i = 0; i < 4; i++) begin
      chki($sformatf("fill_word%0d_time", i), rdy_t[i], RL + (RL + 2) * i);
      chk32($sformatf("fill_word%0d_data", i), rdy_d[i], 32'hA0000000 + i);
    end
    last_rd = 32'hA0000003;

    // read abort: drop ram_rd during WAIT
    seen = 0;
    @(negedge clk);
    ram_address = 16'h0040; ram_rd = 1'b1;
    @(negedge clk);
    if (ram_ready) seen++;
    @(negedge clk);
    if (ram_ready) seen++;
    ram_rd = 1'b0;
    repeat (8) begin @(negedge clk); if (ram_ready) seen++; end
    chki("abort_rd_no_ready", seen, 0);
    chk32("abort_rd_data_held", ram_data_rd, last_rd);
    do_op("abort_then_wr", 1'b0, 1'b1, 16'h0088, 32'h600DF00D, 4'hF, ra, rb, lat);
    chki("abort_then_wr_latency", lat, WL);
    do_op("abort_then_rd", 1'b1, 1'b0, 16'h0088, 32'h0, 4'h0, ra, rb, lat);
    chk32("abort_then_rd_data", ra, 32'h600DF00D);
    last_rd = 32'h600DF00D;

    // write abort at the shortest WAIT
    seen = 0;
    @(negedge clk);
    ram_address = 16'h0088; ram_wr = 1'b1; ram_data_wr = 32'hBAD0BAD0; ram_byte_enable = 4'hF;
    @(negedge clk);
    if (ram_ready) seen++;
    ram_wr = 1'b0;
    repeat (6) begin @(negedge clk); if (ram_ready) seen++; end
    chki("abort_wr_no_ready", seen, 0);
    do_op("abort_wr_check", 1'b1, 1'b0, 16'h0088, 32'h0, 4'h0, ra, rb, lat);
    chk32("abort_wr_not_committed", ra, 32'h600DF00D);
    chki("perr_still_clear", int'(protocol_error), 0);

    // both request lines high in IDLE
    do_op("both", 1'b1, 1'b1, 16'h008C, 32'h0F0F0F0F, 4'hF, ra, rb, lat);
    chki("both_is_write_latency", lat, WL);
    chk32("both_data_rd_unchanged", ra, 32'h600DF00D);
    chki("both_protocol_error", int'(protocol_error), 1);
    do_op("both_readback", 1'b1, 1'b0, 16'h008C, 32'h0, 4'h0, ra, rb, lat);
    chk32("both_readback_data", ra, 32'h0F0F0F0F);
    chki("protocol_error_sticky", int'(protocol_error), 1);

    // reset during WAIT of a write
    seen = 0;
    @(negedge clk);
    ram_address = 16'h0200; ram_wr = 1'b1; ram_data_wr = 32'hFFFFFFFF; ram_byte_enable = 4'hF;
    @(negedge clk);
    if (ram_ready) seen++;
    rst = 1'b1;
    @(negedge clk);
    if (ram_ready) seen++;
    rst = 1'b0; ram_wr = 1'b0;
    chk32("rst_mid_data_rd", ram_data_rd, 32'h0);
    chki("rst_mid_protocol_error", int'(protocol_error), 0);
    chki("rst_mid_state_idle", int'(dbg_state), 0);
    repeat (5) begin @(negedge clk); if (ram_ready) seen++; end
    chki("rst_mid_no_ready", seen, 0);
    do_op("rst_mid_readback", 1'b1, 1'b0, 16'h0200, 32'h0, 4'h0, ra, rb, lat);
    chk32("rst_mid_not_committed", ra, 32'h0);
    last_rd = 32'h0;

    // randomized traffic against the word-array model
    for (int n = 0; n < 40; n++) begin
      is_wr = 1'($urandom_range(0, 1));
      w     = 16'h300 + $urandom_range(0, 15);
      addr  = 16'((w << 2) | $urandom_range(0, 3));
      wd    = $urandom;
      be    = 4'($urandom_range(0, 15));
      if (is_wr) begin
        model_mem[w] = merge(model_mem[w], wd, be);
        exp_q.push_back(last_rd);
      end else begin
        exp_q.push_back(model_mem[w]);
        last_rd = model_mem[w];
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_op($sformatf("rand%0d", n), !is_wr, is_wr, addr, wd, be, ra, rb, lat);
      exp_v = exp_q.pop_front();
      chki($sformatf("rand%0d_latency", n), lat, is_wr ? WL : RL);
      chk32($sformatf("rand%0d_data", n), ra, exp_v);
    end

    // latency-1 instance: back-to-back reads with held request, then a write
    @(negedge clk);
    d1_addr = 16'h0014; d1_rd = 1'b1;
    @(negedge clk);
    chki("l1_rd0_ready", int'(d1_ready), 1);
    chk32("l1_rd0_data", d1_rdata, 32'h55555555);
    d1_addr = 16'h0018;
    @(negedge clk);
    chki("l1_recover_no_ready", int'(d1_ready), 0);
    @(negedge clk);
    chki("l1_idle_no_ready", int'(d1_ready), 0);
    @(negedge clk);
    chki("l1_rd1_ready", int'(d1_ready), 1);
    chk32("l1_rd1_data", d1_rdata, 32'h66666666);
    d1_rd = 1'b0;
    @(negedge clk);
    chki("l1_rd1_pulse_width", int'(d1_ready), 0);
    @(negedge clk);
    d1_addr = 16'h0014; d1_wr = 1'b1; d1_wd = 32'h12345678; d1_be = 4'b0011;
    @(negedge clk);
    chki("l1_wr_ready", int'(d1_ready), 1);
    d1_wr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    d1_rd = 1'b1;
    @(negedge clk);
    chki("l1_rd2_ready", int'(d1_ready), 1);
    chk32("l1_rd2_data", d1_rdata, 32'h55555678);
    d1_rd = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
